// File: rtl/relu_seq_ctrl.sv
// ReLU sequencer: streams X SRAM through a sign test into Y SRAM and
// arbitrates single outstanding CPU reads of Y around the engine's writes.
module relu_seq_ctrl #(
  parameter int unsigned NRows  = 8,
  parameter int unsigned NCols  = 8,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned Data_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              x_re,
  output logic [ADDR_W-1:0] x_addr,
  input  logic [Data_W-1:0] x_rdata,
  output logic              y_we,
  output logic              y_re,
  output logic [ADDR_W-1:0] y_addr,
  output logic [Data_W-1:0] y_wdata,
  input  logic [Data_W-1:0] y_rdata,
  input  logic              cpu_y_re,
  input  logic [31:0]       cpu_y_row,
  input  logic [31:0]       cpu_y_col,
  output logic [Data_W-1:0] cpu_y_rdata,
  output logic              cpu_y_rvalid
);

  localparam int unsigned N     = NRows * NCols;
  localparam int unsigned CNT_W = $clog2(N + 1);
  localparam int unsigned AGE_W = 2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                x_re_q, x_re_d;
  logic [ADDR_W-1:0]   x_addr_q, x_addr_d;
  logic                y_we_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic                pend_q, pend_d;
  logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
  logic                pend_oor_q, pend_oor_d;
  logic [AGE_W-1:0]    age_q, age_d;
  logic                rvalid_q;
  logic                resp_oor_q;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                grant_c;
  logic                keep_c;
  logic                suppress_c;
  logic                y_re_c;
  logic [ADDR_W-1:0]   req_lin_c;
  logic                req_oor_c;

  // CPU request decode: linear address and out-of-range flag
  assign req_lin_c = ADDR_W'(cpu_y_row * NCols + cpu_y_col);
  assign req_oor_c = (cpu_y_row >= NRows) || (cpu_y_col >= NCols);

  // Out-of-range reads never touch the Y port, so they need no free slot
  assign grant_c = pend_q && (pend_oor_q || !y_we_q);
  assign keep_c  = pend_q && !grant_c;
  assign y_re_c  = grant_c && !pend_oor_q;

  // Next-state, issue counter and CPU pending slot
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    x_re_d      = 1'b0;
    x_addr_d    = x_addr_q;
    pend_d      = keep_c;
    pend_addr_d = pend_addr_q;
    pend_oor_d  = pend_oor_q;
    age_d       = '0;
    suppress_c  = 1'b0;

    if (keep_c) begin
      age_d = (age_q == '1) ? age_q : age_q + AGE_W'(1);
    end
    // A slot freed by this cycle's grant can take a new request
    if (cpu_y_re && !keep_c) begin
      pend_d      = 1'b1;
      pend_addr_d = req_lin_c;
      pend_oor_d  = req_oor_c;
    end
    // Skip one read when the request enters its second waiting cycle
    suppress_c = (state_q == S_RUN) && keep_c && (age_d == AGE_W'(1));

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_RUN;
          x_re_d   = 1'b1;
          x_addr_d = '0;
          cnt_d    = CNT_W'(1);
        end
      end
      S_RUN: begin
        if (x_re_q && (cnt_q == CNT_W'(N))) begin
          state_d = S_DRAIN;
        end else if ((cnt_q != CNT_W'(N)) && !suppress_c) begin
          x_re_d   = 1'b1;
          x_addr_d = ADDR_W'(cnt_q);
          cnt_d    = cnt_q + CNT_W'(1);
        end
      end
      S_DRAIN: begin
        if (y_we_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      x_re_q      <= 1'b0;
      x_addr_q    <= '0;
      y_we_q      <= 1'b0;
      wr_addr_q   <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      pend_oor_q  <= 1'b0;
      age_q       <= '0;
      rvalid_q    <= 1'b0;
      resp_oor_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      x_re_q      <= x_re_d;
      x_addr_q    <= x_addr_d;
      y_we_q      <= x_re_q;
      wr_addr_q   <= x_addr_q;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      pend_oor_q  <= pend_oor_d;
      age_q       <= age_d;
      rvalid_q    <= grant_c;
      resp_oor_q  <= grant_c && pend_oor_q;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Write data and CPU read data come straight from the SRAM read ports
  assign busy         = busy_q;
  assign done         = done_q;
  assign x_re         = x_re_q;
  assign x_addr       = x_addr_q;
  assign y_we         = y_we_q;
  assign y_re         = y_re_c;
  assign y_addr       = y_we_q ? wr_addr_q : (y_re_c ? pend_addr_q : '0);
  assign y_wdata      = (y_we_q && !x_rdata[Data_W-1]) ? x_rdata : '0;
  assign cpu_y_rvalid = rvalid_q;
  assign cpu_y_rdata  = (rvalid_q && !resp_oor_q) ? y_rdata : '0;

endmodule
